mdu_multicycle: RTL



---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_multicycle.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the two's-complement magnitude helper.
package mdu_pkg;

    // Widest operand the magnitude helper handles; W must stay below this.
    localparam int MDU_MAX_W = 64;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    // Callers sign-extend a W-bit value into x and keep the low W bits.
    function automatic logic [MDU_MAX_W-1:0] mdu_abs(input logic [MDU_MAX_W-1:0] x);
        return x[MDU_MAX_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/mdu_multicycle.sv
// Bit-serial MULT/MULTU/DIV/DIVU engine that owns HI/LO; W cycles of CALC then one FIX.
// Optional MDU_FAST_MULT_EN: multiplies in one cycle and skip CALC.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         hi_w,
    input  logic         lo_w,
    input  logic [W-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(W) + 1;

    mdu_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic          sa_q, sb_q;
    logic [W-1:0]  dsr_q;
    logic [2*W:0]  acc;

    logic          launch, calc_last, fix, hl_wr_ok;

    // Operand conditioning at launch.
    logic                 op_signed, op_div, q_div;
    logic [MDU_MAX_W-1:0] a_abs, b_abs;
    logic [W-1:0]         a_mag, b_mag;
    logic                 unused_abs;

    assign op_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign op_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign a_abs      = mdu_abs(MDU_MAX_W'($signed(a)));
    assign b_abs      = mdu_abs(MDU_MAX_W'($signed(b)));
    assign a_mag      = op_signed ? a_abs[W-1:0] : a;
    assign b_mag      = op_signed ? b_abs[W-1:0] : b;
    assign unused_abs = ^{a_abs[MDU_MAX_W-1:W], b_abs[MDU_MAX_W-1:W]};
    assign q_div      = (op_q == OP_DIV) || (op_q == OP_DIVU);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) begin
`ifdef MDU_FAST_MULT_EN
                state_nxt = op_div ? S_CALC : S_FIX;
`else
                state_nxt = S_CALC;
`endif
            end
            S_CALC:  if (calc_last) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        launch    = (state == S_IDLE) && start;
        calc_last = (state == S_CALC) && (cnt == CW'(W - 1));
        fix       = (state == S_FIX);
        hl_wr_ok  = (state == S_IDLE);
    end

    // One adder serves both loops: multiply adds the multiplicand into the
    // upper half, divide trial-subtracts the divisor from the shifted remainder.
    logic [W:0]   add_x, add_y;
    logic         add_sub;
    logic [W+1:0] sum;

    always_comb begin
        if (q_div) begin
            add_x   = acc[2*W-1:W-1];
            add_y   = {1'b0, dsr_q};
            add_sub = 1'b1;
        end else begin
            add_x   = acc[2*W:W];
            add_y   = acc[0] ? {1'b0, dsr_q} : '0;
            add_sub = 1'b0;
        end
        sum = {1'b0, add_x} + ({1'b0, add_y} ^ {(W+2){add_sub}}) + (W+2)'(add_sub);
    end

    // Sign correction applied in FIX.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    logic           div_zero;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -acc[2*W-1:0] : acc[2*W-1:0];
        quo_fix  = (sa_q ^ sb_q) ? -acc[W-1:0] : acc[W-1:0];
        rem_fix  = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];
        div_zero = q_div && (dsr_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= OP_MULT;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            dsr_q <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= fix;
            dz   <= fix && div_zero;

            if (launch) begin
                op_q  <= op;
                sa_q  <= op_signed & a[W-1];
                sb_q  <= op_signed & b[W-1];
                cnt   <= '0;
                dsr_q <= op_div ? b_mag : a_mag;
                acc   <= {{(W+1){1'b0}}, (op_div ? a_mag : b_mag)};
`ifdef MDU_FAST_MULT_EN
                if (!op_div) acc <= {1'b0, (2*W)'(a_mag) * (2*W)'(b_mag)};
`endif
            end else if (state == S_CALC) begin
                cnt <= cnt + CW'(1);
                if (!q_div)
                    acc <= {1'b0, sum[W:0], acc[W-1:1]};
                else if (!sum[W+1])
                    acc <= {sum[W:0], acc[W-2:0], 1'b1};
                else
                    acc <= {acc[2*W-1:W-1], acc[W-2:0], 1'b0};
            end

            if (fix) begin
                if (!q_div) begin
                    hi <= prod_fix[2*W-1:W];
                    lo <= prod_fix[W-1:0];
                end else if (!div_zero) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end
            end else if (hl_wr_ok) begin
                if (hi_w) hi <= wd;
                if (lo_w) lo <= wd;
            end
        end
    end

endmodule
